// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, datapath widths and the
// half-bit helper used to find the middle of the start bit.
package uart_pkg;

  localparam int UART_CYCLE_W = 21;
  localparam int UART_DATA_W  = 8;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // Clocks from the start edge to the middle of the start bit.
  function automatic logic [UART_CYCLE_W-1:0] half_period(
    input logic [UART_CYCLE_W-1:0] period
  );
    return period >> 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with a configurable reset value, used to
// bring asynchronous pins into the clk domain.
module sync_ff #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {N{RESET_VAL}};
    end else begin
      chain_r <= {chain_r[N-2:0], d};
    end
  end

  assign q = chain_r[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Shares the runtime baud divisor with the transmitter
// (cycle+1 clocks per bit), samples each bit at its middle and hands bytes
// out on a valid/ready interface with frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [UART_CYCLE_W-1:0] cycle,
  input  logic                    rx_pin,
  output logic [UART_DATA_W-1:0]  rx_data,
  output logic                    rx_data_valid,
  input  logic                    rx_data_ready,
  output logic                    frame_error,
  output logic                    overrun
);

  uart_state_t             state_r;
  logic [UART_CYCLE_W-1:0] cnt_r;
  logic [UART_CYCLE_W-1:0] cycle_lat_r;
  logic [2:0]              bit_cnt_r;
  logic [UART_DATA_W-1:0]  shreg_r;
  logic                    rx_d_r;
  logic                    rx_sync_s;
  logic                    fall_s;
  logic                    accept_s;
  logic                    cnt_zero_s;

  // The line idles high, so the chain resets to 1 to avoid a false start.
  sync_ff #(
    .N         (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_sync_s)
  );

  assign fall_s     = rx_d_r & ~rx_sync_s;
  assign accept_s   = rx_data_valid & rx_data_ready;
  assign cnt_zero_s = (cnt_r == {UART_CYCLE_W{1'b0}});

  // Edge register: previous synchronized line level for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d_r <= 1'b1;
    end else begin
      rx_d_r <= rx_sync_s;
    end
  end

  // Frame FSM with bit timing, byte assembly and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {UART_CYCLE_W{1'b0}};
      cycle_lat_r   <= {UART_CYCLE_W{1'b0}};
      bit_cnt_r     <= 3'd0;
      shreg_r       <= {UART_DATA_W{1'b0}};
      rx_data       <= {UART_DATA_W{1'b0}};
      rx_data_valid <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (accept_s) begin
        rx_data_valid <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            cycle_lat_r <= cycle;
            cnt_r       <= half_period(cycle);
            state_r     <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_zero_s) begin
            if (!rx_sync_s) begin
              cnt_r     <= cycle_lat_r;
              bit_cnt_r <= 3'd0;
              state_r   <= ST_DATA;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - {{(UART_CYCLE_W-1){1'b0}}, 1'b1};
          end
        end

        ST_DATA: begin
          if (cnt_zero_s) begin
            shreg_r[bit_cnt_r] <= rx_sync_s;
            cnt_r              <= cycle_lat_r;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - {{(UART_CYCLE_W-1){1'b0}}, 1'b1};
          end
        end

        ST_STOP: begin
          if (cnt_zero_s) begin
            if (rx_sync_s) begin
              // Acceptance on this edge frees the slot for the new byte.
              if (!rx_data_valid || accept_s) begin
                rx_data       <= shreg_r;
                rx_data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              // Returning at mid-stop lets a start in the late stop half be seen.
              state_r <= ST_IDLE;
            end else begin
              frame_error <= 1'b1;
              state_r     <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r - {{(UART_CYCLE_W-1){1'b0}}, 1'b1};
          end
        end

        ST_BREAK: begin
          // Hold off until the line recovers so a stuck-low line cannot retrigger.
          if (rx_sync_s) begin
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: timing, glitch rejection,
// framing error, overrun, mid-frame reset and a back-to-back stream.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] cycle = 21'd9;
  logic        rx_pin = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready = 1'b1;
  logic        frame_error;
  logic        overrun;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_hi_cnt = 0;
  int valid_rise_cyc = 0;
  int start_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] rx_q[$];

  int fe0;
  int ov0;

  always #5 clk = ~clk;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cycle         (cycle),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    valid_prev <= rx_data_valid;
    if (rst_n) begin
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (rx_data_valid) valid_hi_cnt <= valid_hi_cnt + 1;
      if (rx_data_valid && !valid_prev) valid_rise_cyc <= cyc;
      if (rx_data_valid && rx_data_ready) rx_q.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'bxxxxxxxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // Drive one 8N1 frame, LSB first; called on a falling edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = bits[i];
      if (i == 0) start_cyc = cyc;
      repeat (int'(cycle) + 1) @(negedge clk);
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_data_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0x55 at 10 clk/bit: 2 sync + 1 edge + 4 + 90 + 1 = 98 clocks to valid.
    valid_hi_cnt = 0;
    send_frame(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    check("t1_q_n", rx_q.size(), 32'd1);
    expect_byte("t1_byte", 8'h55);
    check("t1_latency", valid_rise_cyc - start_cyc, 32'd98);
    check("t1_valid_width", valid_hi_cnt, 32'd1);

    // 3-clock low glitch is rejected at mid-start.
    fe0 = fe_cnt;
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_q_n", rx_q.size(), 32'd0);
    check("glitch_ferr", fe_cnt - fe0, 32'd0);
    check("glitch_valid", {31'd0, rx_data_valid}, 32'd0);

    // 0xA3 with a low stop held for 20 clocks.
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (10) @(negedge clk);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    check("ferr_pulses", fe_cnt - fe0, 32'd1);
    check("ferr_valid", {31'd0, rx_data_valid}, 32'd0);
    check("ferr_q_n", rx_q.size(), 32'd0);

    // Overrun: 0x12 held unaccepted while 0x34 arrives.
    ov0 = ov_cnt;
    @(posedge clk);
    #1 rx_data_ready = 1'b0;
    @(negedge clk);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_data", {24'd0, rx_data}, 32'h12);
    check("ovr_valid", {31'd0, rx_data_valid}, 32'd1);
    check("ovr_pulses", ov_cnt - ov0, 32'd1);
    @(posedge clk);
    #1 rx_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_valid_drop", {31'd0, rx_data_valid}, 32'd0);
    check("ovr_q_n", rx_q.size(), 32'd1);
    expect_byte("ovr_byte", 8'h12);
    send_frame(8'h56, 1'b1);
    repeat (5) @(negedge clk);
    expect_byte("after_ovr_byte", 8'h56);
    check("after_ovr_pulses", ov_cnt - ov0, 32'd1);

    // Reset during data bit 4 of 0xFF, then 0x0F.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_pin = 1'b0;
    repeat (10) @(negedge clk);
    rx_pin = 1'b1;
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_valid", {31'd0, rx_data_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("post_rst_q_n", rx_q.size(), 32'd0);
    check("post_rst_data", {24'd0, rx_data}, 32'h00);
    send_frame(8'h0F, 1'b1);
    repeat (5) @(negedge clk);
    check("rst_then_q_n", rx_q.size(), 32'd1);
    expect_byte("rst_then_byte", 8'h0F);
    check("rst_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // Back-to-back stream at cycle=433, as from the transmitter.
    cycle = 21'd433;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    repeat (5) @(negedge clk);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check("loop_q_n", rx_q.size(), 32'd4);
    expect_byte("loop_b0", 8'h00);
    expect_byte("loop_b1", 8'hFF);
    expect_byte("loop_b2", 8'h5A);
    expect_byte("loop_b3", 8'h81);
    check("loop_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
